// File: rtl/hello_world_rgb_if.sv
// hello_world_rgb_if
//   Groups the three on-board RGB LED pins of the Tang Nano.
//   All channels are active-low (0 = lit).
//
//   Signals:
//     led_r  red channel
//     led_g  green channel
//     led_b  blue channel
//
//   Modports:
//     master  drives the pins (the LED sequencer)
//     slave   observes the pins (board pads, testbench)
interface hello_world_rgb_if;
    logic led_r;
    logic led_g;
    logic led_b;

    modport master (output led_r, output led_g, output led_b);
    modport slave  (input  led_r, input  led_g, input  led_b);
endinterface : hello_world_rgb_if

// File: rtl/hello_world_rgb.sv
// hello_world_rgb
//   Board bring-up "hello world": steps the three RGB LED channels through
//   an eight-colour sequence, each colour held for STEP_CYCLES clocks.
//
//   Parameters:
//     STEP_CYCLES  clocks per colour step (>= 2), default 0.5 s at 24 MHz
//     PWM_BITS     PWM counter / duty width (breathing build only)
//
//   Ports:
//     clk   system clock, rising edge
//     rst   synchronous active-high reset
//     leds  hello_world_rgb_if.master, registered active-low LED pins
//
//   Build option:
//     HELLO_WORLD_BREATHE_EN  when defined, each colour fades in with PWM;
//                             a lit channel is driven only while
//                             pwm_cnt < duty, and duty ramps once per PWM
//                             period, restarting at 0 on every colour step.
//
//   state      | meaning
//   -----------+-------------------------------
//   ST_RED     | R lit
//   ST_YELLOW  | R,G lit
//   ST_GREEN   | G lit
//   ST_CYAN    | G,B lit
//   ST_BLUE    | B lit
//   ST_MAGENTA | R,B lit
//   ST_WHITE   | R,G,B lit
//   ST_OFF     | all dark
module hello_world_rgb #(
    parameter int STEP_CYCLES = 12_000_000,
    parameter int PWM_BITS    = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    hello_world_rgb_if.master         leds
);

    if (STEP_CYCLES < 2 || PWM_BITS < 1) begin : g_bad_cfg
        $error("hello_world_rgb: STEP_CYCLES must be >= 2 and PWM_BITS >= 1");
    end

    localparam int STEP_W = $clog2(STEP_CYCLES);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYCLES - 1);

    // Enum order is the display order, so +1 (mod 8) advances the colour
    // and OFF naturally wraps back to RED.
    typedef enum logic [2:0] {
        ST_RED     = 3'd0,
        ST_YELLOW  = 3'd1,
        ST_GREEN   = 3'd2,
        ST_CYAN    = 3'd3,
        ST_BLUE    = 3'd4,
        ST_MAGENTA = 3'd5,
        ST_WHITE   = 3'd6,
        ST_OFF     = 3'd7
    } color_t;

    color_t            state;
    logic [STEP_W-1:0] step_cnt;
    logic              advance;
    logic [2:0]        lit;     // {r,g,b}, 1 = lit
    logic              drive;   // 1 = lit channels may be driven on this cycle

    assign advance = (step_cnt == STEP_LAST);

    always_comb begin
        lit = 3'b000;
        case (state)
            ST_RED:     lit = 3'b100;
            ST_YELLOW:  lit = 3'b110;
            ST_GREEN:   lit = 3'b010;
            ST_CYAN:    lit = 3'b011;
            ST_BLUE:    lit = 3'b001;
            ST_MAGENTA: lit = 3'b101;
            ST_WHITE:   lit = 3'b111;
            ST_OFF:     lit = 3'b000;
            default:    lit = 3'b000;
        endcase
    end

`ifdef HELLO_WORLD_BREATHE_EN
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PWM_BITS-1:0] duty;

    assign drive = (pwm_cnt < duty);

    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt <= '0;
            duty    <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            // A colour advance restarts the fade even if the PWM wraps on
            // the same edge.
            if (advance) begin
                duty <= '0;
            end else if (pwm_cnt == '1 && duty != '1) begin
                duty <= duty + 1'b1;
            end
        end
    end
`else
    assign drive = 1'b1;
`endif

    // Pins are a registered image of the current state, so the colour
    // shown at each edge is the one held before that edge's advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            step_cnt   <= '0;
            state      <= ST_RED;
            leds.led_r <= 1'b1;
            leds.led_g <= 1'b1;
            leds.led_b <= 1'b1;
        end else begin
            if (advance) begin
                step_cnt <= '0;
                state    <= color_t'(state + 3'd1);
            end else begin
                step_cnt <= step_cnt + 1'b1;
            end
            leds.led_r <= ~(lit[2] & drive);
            leds.led_g <= ~(lit[1] & drive);
            leds.led_b <= ~(lit[0] & drive);
        end
    end

endmodule : hello_world_rgb

// File: tb/tb_hello_world_rgb.sv
module tb_hello_world_rgb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [2:0] got, input logic [2:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %b expected %b", tag, got, exp);
        end
    endtask

    // One rising edge, then settle on the falling edge for sampling/driving.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Pin pattern {r,g,b} of colour k, hand-derived (active-low).
    function automatic logic [2:0] pins_of(input int k);
        case (k % 8)
            0: return 3'b011;   // RED
            1: return 3'b001;   // YELLOW
            2: return 3'b101;   // GREEN
            3: return 3'b100;   // CYAN
            4: return 3'b110;   // BLUE
            5: return 3'b010;   // MAGENTA
            6: return 3'b000;   // WHITE
            default: return 3'b111; // OFF
        endcase
    endfunction

`ifndef HELLO_WORLD_BREATHE_EN
    logic rst4 = 1'b1;
    logic rst2 = 1'b1;
    logic rst_def = 1'b1;

    hello_world_rgb_if if4 ();
    hello_world_rgb_if if2 ();
    hello_world_rgb_if if_def ();

    hello_world_rgb #(.STEP_CYCLES(4)) dut4 (.clk(clk), .rst(rst4), .leds(if4.master));
    hello_world_rgb #(.STEP_CYCLES(2)) dut2 (.clk(clk), .rst(rst2), .leds(if2.master));
    hello_world_rgb dut_def (.clk(clk), .rst(rst_def), .leds(if_def.master));

    wire [2:0] pins4   = {if4.led_r, if4.led_g, if4.led_b};
    wire [2:0] pins2   = {if2.led_r, if2.led_g, if2.led_b};
    wire [2:0] pins_df = {if_def.led_r, if_def.led_g, if_def.led_b};

    initial begin
        @(negedge clk);
        // Reset held for 3 edges: dark throughout.
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val($sformatf("reset4_%0d", i), pins4, 3'b111);
        end
        rst4 = 1'b0;
        // Edges E1 .. E1+49: full sequence, wrap at 32, into BLUE cycle 1.
        for (int c = 0; c < 50; c++) begin
            tick();
            check_val($sformatf("seq4_c%0d", c), pins4, pins_of(c / 4));
        end
        // Reset on BLUE cycle 2 (edge E1+50).
        rst4 = 1'b1;
        tick();
        check_val("midreset_dark", pins4, 3'b111);
        rst4 = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            check_val($sformatf("midreset_c%0d", c), pins4, pins_of(c / 4));
        end

        // Minimum step length.
        tick();
        check_val("reset2", pins2, 3'b111);
        rst2 = 1'b0;
        for (int c = 0; c < 17; c++) begin
            tick();
            check_val($sformatf("seq2_c%0d", c), pins2, pins_of(c / 2));
        end

        // Default step length: no advance within the run.
        tick();
        check_val("reset_def", pins_df, 3'b111);
        rst_def = 1'b0;
        for (int c = 0; c < 50_000; c++) begin
            tick();
            if (pins_df !== 3'b011 || c % 10_000 == 0)
                check_val($sformatf("default_c%0d", c), pins_df, 3'b011);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
`else
    logic rst_br = 1'b1;

    hello_world_rgb_if if_br ();

    hello_world_rgb #(.STEP_CYCLES(64), .PWM_BITS(2)) dut_br (
        .clk(clk), .rst(rst_br), .leds(if_br.master));

    wire [2:0] pins_br = {if_br.led_r, if_br.led_g, if_br.led_b};

    initial begin
        logic [2:0] exp;
        int duty_m;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val($sformatf("reset_br_%0d", i), pins_br, 3'b111);
        end
        rst_br = 1'b0;
        for (int c = 0; c < 68; c++) begin
            tick();
            if (c < 64) begin
                duty_m = (c / 4 > 3) ? 3 : c / 4;
                exp = ((c % 4) < duty_m) ? 3'b011 : 3'b111;
            end else begin
                exp = 3'b111;   // YELLOW step starts dark
            end
            check_val($sformatf("breathe_c%0d", c), pins_br, exp);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
`endif

endmodule : tb_hello_world_rgb
